id_ex_stage: RTL

ID/EX pipeline register and EX operand-forwarding stage of the 5-stage MIPS pipeline. It captures decoded instruction fields and register-file data at the end of ID and resolves the ALU operands from EX/MEM and MEM/WB results. It presents the ALU operation code, both operands and the shift amount directly to the ALU, and carries store data and writeback controls forward to EX/MEM. It also detects load-use hazards and inserts bubbles, and honours branch flush and global hold.

---
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Signal bundle between ID, the ID/EX stage, the forwarding sources and the ALU.
// master drives ID fields and forwarding results; slave is the stage itself.
interface id_ex_stage_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_dest;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;
    logic                      id_mem_to_reg;
    logic                      id_alu_src;
    logic [OP_W-1:0]           id_alu_op;
    logic [DATA_WIDTH-1:0]     id_rs_data;
    logic [DATA_WIDTH-1:0]     id_rt_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [SHAMT_W-1:0]        id_shamt;

    logic                      mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_dest;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0]     wb_result;

    logic                      load_use_stall;
    logic                      ex_valid;
    logic [OP_W-1:0]           ex_alu_operation;
    logic [DATA_WIDTH-1:0]     ex_a;
    logic [DATA_WIDTH-1:0]     ex_b;
    logic [SHAMT_W-1:0]        ex_shamt;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_dest;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      ex_mem_to_reg;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
               id_rs_data, id_rt_data, id_imm, id_shamt,
               mem_reg_write, mem_dest, mem_result,
               wb_reg_write, wb_dest, wb_result,
        input  load_use_stall, ex_valid, ex_alu_operation, ex_a, ex_b,
               ex_shamt, ex_store_data, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
               id_rs_data, id_rt_data, id_imm, id_shamt,
               mem_reg_write, mem_dest, mem_result,
               wb_reg_write, wb_dest, wb_result,
        output load_use_stall, ex_valid, ex_alu_operation, ex_a, ex_b,
               ex_shamt, ex_store_data, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use bubble insertion.
// A bubble is the all-zero register image, so reset, flush and stall share one encoding.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         flush,
    id_ex_stage_if.slave bus
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      mem_to_reg;
        logic                      alu_src;
        logic [OP_W-1:0]           alu_op;
        logic [DATA_WIDTH-1:0]     rs_data;
        logic [DATA_WIDTH-1:0]     rt_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [SHAMT_W-1:0]        shamt;
    } stage_t;

    stage_t                q;
    stage_t                id_in;
    logic                  stall_c;
    logic [DATA_WIDTH-1:0] fwd_rs;
    logic [DATA_WIDTH-1:0] fwd_rt;

    always_comb begin
        id_in            = '0;
        id_in.valid      = bus.id_valid;
        id_in.rs         = bus.id_rs;
        id_in.rt         = bus.id_rt;
        id_in.dest       = bus.id_dest;
        id_in.reg_write  = bus.id_reg_write;
        id_in.mem_read   = bus.id_mem_read;
        id_in.mem_write  = bus.id_mem_write;
        id_in.mem_to_reg = bus.id_mem_to_reg;
        id_in.alu_src    = bus.id_alu_src;
        id_in.alu_op     = bus.id_alu_op;
        id_in.rs_data    = bus.id_rs_data;
        id_in.rt_data    = bus.id_rt_data;
        id_in.imm        = bus.id_imm;
        id_in.shamt      = bus.id_shamt;
    end

    // rt is compared even for immediate-form instructions: conservative but simple
    always_comb begin
        stall_c = q.valid && q.mem_read && (q.dest != '0) && bus.id_valid &&
                  ((q.dest == bus.id_rs) || (q.dest == bus.id_rt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (!hold) begin
            if (flush || stall_c) begin
                q <= '0;
            end else begin
                q <= id_in;
            end
        end
    end

    // MEM/WB applied first so a matching EX/MEM result overrides it
    always_comb begin
        fwd_rs = q.rs_data;
        fwd_rt = q.rt_data;
        if (bus.wb_reg_write && (bus.wb_dest == q.rs) && (q.rs != '0)) begin
            fwd_rs = bus.wb_result;
        end
        if (bus.mem_reg_write && (bus.mem_dest == q.rs) && (q.rs != '0)) begin
            fwd_rs = bus.mem_result;
        end
        if (bus.wb_reg_write && (bus.wb_dest == q.rt) && (q.rt != '0)) begin
            fwd_rt = bus.wb_result;
        end
        if (bus.mem_reg_write && (bus.mem_dest == q.rt) && (q.rt != '0)) begin
            fwd_rt = bus.mem_result;
        end
    end

    assign bus.load_use_stall   = stall_c;
    assign bus.ex_valid         = q.valid;
    assign bus.ex_alu_operation = q.alu_op;
    assign bus.ex_a             = fwd_rs;
    assign bus.ex_b             = q.alu_src ? q.imm : fwd_rt;
    assign bus.ex_shamt         = q.shamt;
    assign bus.ex_store_data    = fwd_rt;
    assign bus.ex_dest          = q.dest;
    assign bus.ex_reg_write     = q.reg_write;
    assign bus.ex_mem_read      = q.mem_read;
    assign bus.ex_mem_write     = q.mem_write;
    assign bus.ex_mem_to_reg    = q.mem_to_reg;
endmodule
